data_memory_lat: RTL

Parametrised data memory for the 5-stage pipelined datapath's MEM stage. Replaces the fixed 16×16 combinational-read memory with a configurable width/depth array behind a valid/ready request port. Supports byte-lane writes, a programmable response latency that stalls the pipeline via `req_ready`, and out-of-range address detection. Reset loads a known test pattern.

---
 rtl/data_memory_lat_if.sv | 27 ++
 rtl/data_memory_lat.sv | 115 +++++++++++
 2 files changed

// File: rtl/data_memory_lat_if.sv
// Request/response port of the MEM-stage data memory:
// one valid/ready request channel and a single-cycle response pulse.
interface data_memory_lat_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_be;
    logic                  resp_valid;
    logic [DATA_W-1:0]     resp_rdata;
    logic                  resp_err;
    logic [7:0]            err_count;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be,
        input  req_ready, resp_valid, resp_rdata, resp_err, err_count
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be,
        output req_ready, resp_valid, resp_rdata, resp_err, err_count
    );
endinterface

// File: rtl/data_memory_lat.sv
// Word-addressed data memory with byte-lane writes, a fixed response
// latency that back-pressures via req_ready, and range checking.
module data_memory_lat #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 16,
    parameter int LAT    = 1
) (
    input logic clk,
    input logic rst,
    data_memory_lat_if.slave bus
);
    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic {IDLE, WAIT} state_t;

    logic [DATA_W-1:0] mem [DEPTH];
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              accept;
    logic              in_range;
    logic              fire;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] rd_now;
    logic [DATA_W-1:0] pend_data;
    logic              pend_err;
    logic [DATA_W-1:0] out_data;
    logic              out_err;

    assign bus.req_ready = (cnt_q == '0);
    assign accept   = bus.req_valid && bus.req_ready;
    assign in_range = {1'b0, bus.req_addr} < (ADDR_W + 1)'(DEPTH);
    assign idx      = bus.req_addr[IDX_W-1:0];
    assign rd_now   = (in_range && !bus.req_write) ? mem[idx] : '0;

    // With LAT=1 the response leaves on the acceptance edge itself.
    assign out_data = (LAT == 1) ? rd_now : pend_data;
    assign out_err  = (LAT == 1) ? !in_range : pend_err;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fire    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (LAT == 1) begin
                        fire = 1'b1;
                    end else begin
                        cnt_d   = CNT_W'(LAT - 1);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    fire    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
            bus.err_count  <= '0;
            pend_data      <= '0;
            pend_err       <= 1'b0;
        end else begin
            bus.resp_valid <= fire;
            if (fire) begin
                bus.resp_rdata <= out_data;
                bus.resp_err   <= out_err;
            end
            if (accept) begin
                pend_data <= rd_now;
                pend_err  <= !in_range;
                if (!in_range && bus.err_count != 8'hFF)
                    bus.err_count <= bus.err_count + 8'd1;
            end
        end
    end

    // Reset preloads word i with i so reads are checkable out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= DATA_W'(i);
        end else if (accept && in_range && bus.req_write) begin
            for (int j = 0; j < NB; j++)
                if (bus.req_be[j])
                    mem[idx][8*j +: 8] <= bus.req_wdata[8*j +: 8];
        end
    end
endmodule
